// File: rtl/motor_pkg.sv
// Shared constants and types for the motor ramp sequencer: H-bridge direction codes,
// sequencer states and the applied-duty width.
package motor_pkg;
   localparam int DUTY_W = 8;

   localparam logic [1:0] DIR_FWD   = 2'b10;
   localparam logic [1:0] DIR_REV   = 2'b01;
   localparam logic [1:0] DIR_COAST = 2'b00;
   localparam logic [1:0] DIR_BRAKE = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      RAMP,
      RAMP_DOWN,
      DEAD
   } state_e;
endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: tick is high for one clock out of every DIV clocks.
// Shared with the display refresh logic, so it knows nothing about motors.
module tick_gen #(
   parameter int DIV = 100000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tick = (cnt_q == LAST);
endmodule

// File: rtl/motor_ramp_sequencer.sv
// Slew-limited duty/direction sequencer for the H-bridge: ramps to zero and coasts for a dead
// time before any reversal. Optional command watchdog enabled by defining CMD_WATCHDOG_EN.
module motor_ramp_sequencer
   import motor_pkg::*;
#(
   parameter int RAMP_DIV    = 100000,
   parameter int STEP        = 1,
   parameter int DEAD_CYCLES = 10000
`ifdef CMD_WATCHDOG_EN
   ,
   parameter int WDOG_CYCLES = 100000000
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   input  logic [1:0]        cmd_dir,
   input  logic [DUTY_W-1:0] cmd_duty,
   output logic [DUTY_W-1:0] duty,
   output logic [1:0]        dir,
   output logic              busy,
   output logic              done
`ifdef CMD_WATCHDOG_EN
   ,
   output logic              wdog_trip
`endif
);
   localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam logic [DW-1:0]     DEAD_LOAD = DW'(DEAD_CYCLES - 1);
   localparam logic [DUTY_W:0]   STEP_W    = (DUTY_W + 1)'(STEP);
   localparam logic [DUTY_W-1:0] STEP_N    = DUTY_W'(STEP);

   state_e            state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d, tgt_duty_q, tgt_duty_d;
   logic [1:0]        dir_q, dir_d, tgt_dir_q, tgt_dir_d;
   logic [DW-1:0]     dead_q, dead_d;
   logic              done_q, done_d;
   logic              tick;
   logic              force_coast;

   // One slew step toward tgt in 9-bit arithmetic, clamped so it never passes the target.
   function automatic logic [DUTY_W-1:0] ramp_toward(input logic [DUTY_W-1:0] cur,
                                                     input logic [DUTY_W-1:0] tgt);
      logic [DUTY_W:0] up_sum, down_thr;
      up_sum   = {1'b0, cur} + STEP_W;
      down_thr = {1'b0, tgt} + STEP_W;
      if (cur < tgt) ramp_toward = (up_sum > {1'b0, tgt}) ? tgt : up_sum[DUTY_W-1:0];
      else           ramp_toward = ({1'b0, cur} > down_thr) ? cur - STEP_N : tgt;
   endfunction

   tick_gen #(.DIV(RAMP_DIV)) u_tick (
      .clk  (clk),
      .reset(reset),
      .tick (tick)
   );

`ifdef CMD_WATCHDOG_EN
   localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   localparam logic [WW-1:0] WLAST = WW'(WDOG_CYCLES - 1);

   logic [WW-1:0] wdog_q, wdog_d;
   logic          wdog_trip_q;

   always_comb begin
      wdog_d = wdog_q;
      if (cmd_valid)          wdog_d = '0;
      else if (wdog_q != WLAST) wdog_d = wdog_q + 1'b1;
      force_coast = !cmd_valid && (wdog_q != WLAST) && (wdog_d == WLAST);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wdog_q      <= '0;
         wdog_trip_q <= 1'b0;
      end else begin
         wdog_q      <= wdog_d;
         wdog_trip_q <= force_coast;
      end
   end

   assign wdog_trip = wdog_trip_q;
`else
   assign force_coast = 1'b0;
`endif

   always_comb begin
      tgt_dir_d  = tgt_dir_q;
      tgt_duty_d = tgt_duty_q;
      if (cmd_valid) begin
         tgt_dir_d  = cmd_dir;
         tgt_duty_d = (cmd_dir == DIR_COAST || cmd_dir == DIR_BRAKE) ? '0 : cmd_duty;
      end else if (force_coast) begin
         tgt_dir_d  = DIR_COAST;
         tgt_duty_d = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      dir_d   = dir_q;
      dead_d  = dead_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (tgt_dir_q != dir_q)        state_d = RAMP_DOWN;
            else if (tgt_duty_q != duty_q) state_d = RAMP;
         end
         RAMP: begin
            if (tgt_dir_q != dir_q) begin
               state_d = RAMP_DOWN;
            end else if (duty_q == tgt_duty_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (tick) begin
               duty_d = ramp_toward(duty_q, tgt_duty_q);
            end
         end
         RAMP_DOWN: begin
            if (tgt_dir_q == dir_q) begin
               state_d = RAMP;
            end else if (duty_q == '0) begin
               dir_d   = DIR_COAST;
               dead_d  = DEAD_LOAD;
               state_d = DEAD;
            end else if (tick) begin
               duty_d = ramp_toward(duty_q, '0);
            end
         end
         DEAD: begin
            // Direction is taken from the target as it stands when the dead time expires.
            if (dead_q == '0) begin
               dir_d = tgt_dir_q;
               if (tgt_duty_q != '0) begin
                  state_d = RAMP;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               dead_d = dead_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         duty_q     <= '0;
         dir_q      <= DIR_COAST;
         tgt_dir_q  <= DIR_COAST;
         tgt_duty_q <= '0;
         dead_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         duty_q     <= duty_d;
         dir_q      <= dir_d;
         tgt_dir_q  <= tgt_dir_d;
         tgt_duty_q <= tgt_duty_d;
         dead_q     <= dead_d;
         done_q     <= done_d;
      end
   end

   assign duty = duty_q;
   assign dir  = dir_q;
   assign busy = (state_q != IDLE);
   assign done = done_q;
endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Directed bench for motor_ramp_sequencer: a table of commands with hand-computed duty
// sequences, plus hand-written sequences for abort, repeat-command and async reset.
module tb_motor_ramp_sequencer;
   localparam int RAMP_DIV    = 4;
   localparam int STEP        = 16;
   localparam int DEAD_CYCLES = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic [1:0] cmd_dir;
   logic [7:0] cmd_duty;
   logic [7:0] duty;
   logic [1:0] dir;
   logic       busy;
   logic       done;
`ifdef CMD_WATCHDOG_EN
   logic       wdog_trip;
`endif

   motor_ramp_sequencer #(
      .RAMP_DIV   (RAMP_DIV),
      .STEP       (STEP),
      .DEAD_CYCLES(DEAD_CYCLES)
`ifdef CMD_WATCHDOG_EN
      ,
      .WDOG_CYCLES(50)
`endif
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .cmd_valid(cmd_valid),
      .cmd_dir  (cmd_dir),
      .cmd_duty (cmd_duty),
      .duty     (duty),
      .dir      (dir),
      .busy     (busy),
      .done     (done)
`ifdef CMD_WATCHDOG_EN
      ,
      .wdog_trip(wdog_trip)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]      cdir;
      logic [7:0]      cduty;
      int              nseq;
      logic [0:7][7:0] seq;
      int              ncoast;
      logic [1:0]      fdir;
      logic [7:0]      fduty;
   } vec_t;

   vec_t vecs[8];

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] seen_q[$];
   int         seen_cyc[$];
   int         coast_cnt, done_cnt, not_fwd_cnt, timed_out;
   logic       busy_at_done;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Caller is positioned at a falling edge; command is latched on the next rising edge.
   task automatic apply_cmd(input logic [1:0] d, input logic [7:0] du);
      cmd_valid = 1'b1;
      cmd_dir   = d;
      cmd_duty  = du;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic monitor(input int max_cyc);
      logic [7:0] last;
      int         n;
      bit         got;
      seen_q.delete();
      seen_cyc.delete();
      coast_cnt    = 0;
      done_cnt     = 0;
      not_fwd_cnt  = 0;
      busy_at_done = 1'b1;
      last = duty;
      got  = 1'b0;
      n    = 0;
      while (!got && n < max_cyc) begin
         @(negedge clk);
         n++;
         if (duty != last) begin
            seen_q.push_back(duty);
            seen_cyc.push_back(cyc);
            last = duty;
         end
         if (dir == 2'b00) coast_cnt++;
         if (dir != 2'b10) not_fwd_cnt++;
         if (done) begin
            done_cnt++;
            got = 1'b1;
            busy_at_done = busy;
         end
      end
      timed_out = got ? 0 : 1;
      repeat (4) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
   endtask

   task automatic check_seq(input string tag, input int nseq, input logic [0:7][7:0] seq);
      int bad_gaps;
      check({tag, " nchanges"}, seen_q.size(), nseq);
      for (int i = 0; i < nseq; i++) begin
         if (i < seen_q.size())
            check($sformatf("%s duty[%0d]", tag, i), int'(seen_q[i]), int'(seq[i]));
      end
      bad_gaps = 0;
      for (int i = 1; i < seen_cyc.size(); i++)
         if (((seen_cyc[i] - seen_cyc[i-1]) % RAMP_DIV) != 0) bad_gaps++;
      check({tag, " off-tick changes"}, bad_gaps, 0);
   endtask

   initial begin
      int n;
      int busy_hi, done_hi;
      logic [0:7][7:0] s;

      vecs[0] = '{2'b10, 8'd64,  4, {8'd16, 8'd32, 8'd48, 8'd64, 32'd0},               10, 2'b10, 8'd64};
      vecs[1] = '{2'b10, 8'd40,  2, {8'd48, 8'd40, 48'd0},                              0, 2'b10, 8'd40};
      vecs[2] = '{2'b10, 8'd64,  2, {8'd56, 8'd64, 48'd0},                              0, 2'b10, 8'd64};
      vecs[3] = '{2'b01, 8'd32,  6, {8'd48, 8'd32, 8'd16, 8'd0, 8'd16, 8'd32, 16'd0},   8, 2'b01, 8'd32};
      vecs[4] = '{2'b00, 8'd200, 2, {8'd16, 8'd0, 48'd0},                               9, 2'b00, 8'd0};
      vecs[5] = '{2'b11, 8'd0,   0, 64'd0,                                             10, 2'b11, 8'd0};
      vecs[6] = '{2'b10, 8'd100, 7, {8'd16, 8'd32, 8'd48, 8'd64, 8'd80, 8'd96, 8'd100, 8'd0},
                  8, 2'b10, 8'd100};
      vecs[7] = '{2'b10, 8'd64,  3, {8'd84, 8'd68, 8'd64, 40'd0},                       0, 2'b10, 8'd64};

      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_dir   = 2'b00;
      cmd_duty  = 8'd0;
      repeat (3) @(negedge clk);
      check("reset duty", int'(duty), 0);
      check("reset dir",  int'(dir),  0);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      reset = 1'b0;

      for (int v = 0; v < 8; v++) begin
         string tag;
         tag = $sformatf("vec%0d", v);
         @(negedge clk);
         apply_cmd(vecs[v].cdir, vecs[v].cduty);
         monitor(120);
         check({tag, " timeout"}, timed_out, 0);
         check_seq(tag, vecs[v].nseq, vecs[v].seq);
         check({tag, " coast cycles"}, coast_cnt, vecs[v].ncoast);
         check({tag, " final dir"}, int'(dir), int'(vecs[v].fdir));
         check({tag, " final duty"}, int'(duty), int'(vecs[v].fduty));
         check({tag, " done pulses"}, done_cnt, 1);
         check({tag, " busy at done"}, int'(busy_at_done), 0);
      end

      // Reversal aborted in RAMP_DOWN at duty 32: back to ramping up, no dead time.
      @(negedge clk);
      apply_cmd(2'b01, 8'd32);
      n = 0;
      while (duty != 8'd32 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("abort reach 32", int'(duty), 32);
      check("abort dir before", int'(dir), 2);
      apply_cmd(2'b10, 8'd64);
      monitor(60);
      check("abort timeout", timed_out, 0);
      s = {8'd48, 8'd64, 48'd0};
      check_seq("abort", 2, s);
      check("abort dir left fwd", not_fwd_cnt, 0);
      check("abort done pulses", done_cnt, 1);

      // Same target again: nothing to do, so no busy and no done.
      @(negedge clk);
      apply_cmd(2'b10, 8'd64);
      busy_hi = 0;
      done_hi = 0;
      repeat (10) begin
         @(negedge clk);
         if (busy) busy_hi++;
         if (done) done_hi++;
      end
      check("repeat busy cycles", busy_hi, 0);
      check("repeat done cycles", done_hi, 0);

      // Asynchronous reset while ramping down at duty 48.
      @(negedge clk);
      apply_cmd(2'b10, 8'd0);
      n = 0;
      while (duty != 8'd48 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("midramp reach 48", int'(duty), 48);
      check("midramp busy", int'(busy), 1);
      #2;
      reset = 1'b1;
      #1;
      check("async reset duty", int'(duty), 0);
      check("async reset dir",  int'(dir),  0);
      check("async reset busy", int'(busy), 0);
      @(negedge clk);
      reset = 1'b0;

`ifdef CMD_WATCHDOG_EN
      begin
         int trips;
         @(negedge clk);
         apply_cmd(2'b10, 8'd64);
         monitor(80);
         check("wdog ramp up duty", int'(duty), 64);
         trips = 0;
         n = 0;
         done_hi = 0;
         while (done_hi == 0 && n < 200) begin
            @(negedge clk);
            n++;
            if (wdog_trip) trips++;
            if (done) done_hi++;
         end
         check("wdog trip pulses", trips, 1);
         check("wdog done", done_hi, 1);
         check("wdog final duty", int'(duty), 0);
         check("wdog final dir", int'(dir), 0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
